// File: rtl/fp_arith_pkg.sv
// Shared types and constants for the floating-point multiply datapath:
// mantissa/partial-product widths, the partial-product array and the accumulator FSM states.
package fp_arith_pkg;

    localparam int MANT_W = 24;
    localparam int NUM_PP = MANT_W / 2;
    localparam int PP_W   = 2 * MANT_W;

    typedef logic [PP_W-1:0] pp_t;
    typedef pp_t pp_array_t [NUM_PP];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } ppacc_state_t;

    // Two's complement add; the carry out of the top bit is dropped.
    function automatic pp_t pp_wrap_add(input pp_t a, input pp_t b);
        return pp_t'(a + b);
    endfunction

endpackage

// File: rtl/fp_pp_adder_tree.sv
// Combinational sum of K partial products plus the running accumulator,
// wrapping modulo 2^PP_W.
module fp_pp_adder_tree
    import fp_arith_pkg::*;
#(
    parameter int K = 2
) (
    input  logic [K*PP_W-1:0] ops,
    input  logic [PP_W-1:0]   acc,
    output logic [PP_W-1:0]   sum
);

    pp_t sum_s;

    // Chain the K operands onto the accumulator
    always_comb begin
        sum_s = acc;
        for (int k = 0; k < K; k++) begin
            sum_s = pp_wrap_add(sum_s, ops[k*PP_W +: PP_W]);
        end
    end

    assign sum = sum_s;

endmodule

// File: rtl/fp_mul_pp_accumulator.sv
// Iterative partial-product accumulator for the mantissa multiplier: captures all
// partial products in one handshake, adds PP_PER_CYCLE per clock, presents the product.
module fp_mul_pp_accumulator
    import fp_arith_pkg::*;
#(
    parameter int PP_PER_CYCLE = 2,
    parameter int TAG_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PP*PP_W-1:0] pp,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PP_W-1:0]        product,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int STEPS = NUM_PP / PP_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    ppacc_state_t                  state_r;
    pp_array_t                     pp_r;
    logic [TAG_W-1:0]              tag_r;
    pp_t                           acc_r;
    logic [CNT_W-1:0]              cnt_r;
    logic [PP_PER_CYCLE*PP_W-1:0]  ops_s;
    pp_t                           sum_s;

    // Route the group of captured partial products selected by cnt to the adder
    always_comb begin
        logic [IDX_W-1:0] idx;
        ops_s = '0;
        idx   = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            idx = IDX_W'(int'(cnt_r) * PP_PER_CYCLE + k);
            ops_s[k*PP_W +: PP_W] = pp_r[idx];
        end
    end

    fp_pp_adder_tree #(
        .K   (PP_PER_CYCLE)
    ) u_adder (
        .ops (ops_s),
        .acc (acc_r),
        .sum (sum_s)
    );

    // Control FSM with capture registers and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            tag_r     <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            product   <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_PP; i++) begin
                            pp_r[i] <= pp[i*PP_W +: PP_W];
                        end
                        tag_r    <= in_tag;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        state_r  <= ACCUM;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc_r <= sum_s;
                    if (cnt_r == CNT_LAST) begin
                        product   <= sum_s;
                        out_tag   <= tag_r;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result is held until downstream takes it; no overlap with a new accept
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_pp_accumulator.sv
// Scoreboard bench for fp_mul_pp_accumulator: directed corner cases, a Booth-encoded
// multiply model, and randomized traffic with random downstream backpressure.
module tb_fp_mul_pp_accumulator;

    localparam int W  = 48;
    localparam int N  = 12;
    localparam int TW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] pp;
    logic [TW-1:0]  in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   product;
    logic [TW-1:0]  out_tag;
    logic           busy;

    typedef struct {
        logic [W-1:0]  p;
        logic [TW-1:0] t;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   rand_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_pp_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp        (pp),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd_pp();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return 48'hFFFF_FFFF_FFFF;
            1: return 48'h8000_0000_0000;
            default: return r[W-1:0];
        endcase
    endfunction

    function automatic logic [N*W-1:0] rnd_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = rnd_pp();
        return v;
    endfunction

    // Reference: integer sum of all partial products, reduced modulo 2^48 at the end
    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] v);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < N; i++) s = s + {16'd0, v[i*W +: W]};
        return s[W-1:0];
    endfunction

    // Radix-4 Booth partial products of unsigned a*b; the top digit absorbs the
    // unsigned correction (+4 when b[23] is set) so 12 products suffice
    function automatic logic [N*W-1:0] booth_pps(input logic [23:0] a, input logic [23:0] b);
        logic [24:0]    bx;
        logic [N*W-1:0] v;
        logic [W-1:0]   m;
        int             d;
        bx = {b, 1'b0};
        v  = '0;
        for (int i = 0; i < N; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            if (i == N - 1) d = d + 4 * int'(b[23]);
            m = ({24'd0, a} * W'(d < 0 ? -d : d)) << (2 * i);
            if (d < 0) m = -m;
            v[i*W +: W] = m;
        end
        return v;
    endfunction

    // Call aligned just after a rising edge; returns just after the accept edge
    task automatic send(input logic [N*W-1:0] v, input logic [TW-1:0] t,
                        input logic [W-1:0] e, input bit push);
        bit   got = 1'b0;
        exp_t x;
        pp       = v;
        in_tag   = t;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                x.p = e;
                x.t = t;
                x.acc = cyc + 1;
                if (push) q.push_back(x);
                last_acc = cyc + 1;
                got = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: tag %h never accepted", t);
        end
        in_valid = 1'b0;
        pp       = rnd_vec();
        in_tag   = ~t;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] v;
        logic [31:0]    ra;
        logic [31:0]    rb;
        int             a1;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp        = '0;
        in_tag    = '0;

        // Monitor: every cycle a result is presented it must match the oldest expectation
        fork
            begin
                bit   pv = 1'b0;
                exp_t x;
                forever begin
                    @(negedge clk);
                    if (!reset && out_valid) begin
                        if (q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL spurious_out_valid: product %h tag %h with nothing pending",
                                     product, out_tag);
                        end else begin
                            if (!pv) chk("latency", 64'(cyc - q[0].acc), 64'd6);
                            chk("product", 64'(product), 64'(q[0].p));
                            chk("out_tag", 64'(out_tag), 64'(q[0].t));
                            chk("in_ready_in_done", 64'(in_ready), 64'd0);
                            if (out_ready) x = q.pop_front();
                        end
                    end
                    pv = out_valid && !reset;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product",   64'(product),   64'd0);
        chk("reset_out_tag",   64'(out_tag),   64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_busy",      64'(busy),      64'd0);
        @(posedge clk);
        #1;

        // Single unit partial product
        v = '0;
        v[0 +: W] = 48'h1;
        send(v, 8'hA5, 48'h1, 1'b1);
        wait_drain();

        // Twelve copies of -1
        v = '1;
        send(v, 8'h5A, 48'hFFFF_FFFF_FFF4, 1'b1);
        wait_drain();

        // Wrap past 2^48
        v = '0;
        v[0 +: W] = 48'h8000_0000_0000;
        v[W +: W] = 48'h8000_0000_0000;
        send(v, 8'h33, 48'h0, 1'b1);
        wait_drain();

        // Backpressure: hold the result for ten extra cycles
        out_ready = 1'b0;
        v = rnd_vec();
        send(v, 8'hC3, ref_sum(v), 1'b1);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_busy",      64'(busy),      64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Reset during the third accumulation cycle discards the transaction
        v = rnd_vec();
        send(v, 8'h77, 48'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("accum_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_product",   64'(product),   64'd0);
        chk("midreset_out_tag",   64'(out_tag),   64'd0);
        chk("midreset_in_ready",  64'(in_ready),  64'd1);
        chk("midreset_busy",      64'(busy),      64'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        // Booth end-to-end, back-to-back, checking initiation interval
        send(booth_pps(24'hFFFFFF, 24'hFFFFFF), 8'd1, 48'hFFFF_FE00_0001, 1'b1);
        a1 = last_acc;
        send(booth_pps(24'h800000, 24'h800000), 8'd2, 48'h4000_0000_0000, 1'b1);
        chk("initiation_interval", 64'(last_acc - a1), 64'd8);
        wait_drain();

        // Randomized traffic with random downstream stalls
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int g;
                    g = int'($urandom_range(0, 2));
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    if (i % 2 == 0) begin
                        v = rnd_vec();
                        send(v, TW'(i + 8'h10), ref_sum(v), 1'b1);
                    end else begin
                        ra = $urandom();
                        rb = $urandom();
                        send(booth_pps(ra[23:0], rb[23:0]), TW'(i + 8'h10),
                             48'({24'd0, ra[23:0]} * {24'd0, rb[23:0]}), 1'b1);
                    end
                end
                wait_drain();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
